// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute-stage blocks: multiplier FSM states
// and word/iteration constants.
package mips_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned MUL_ITER = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        NEG_LO = 3'd2,
        NEG_HI = 3'd3,
        DONE   = 3'd4
    } mul_state_t;

endpackage

// File: rtl/adder_32bits_cla.sv
// Word-wide carry-lookahead adder built from 4-bit CLA cells whose group
// propagate/generate terms form the inter-cell carry chain.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       pg,
    output logic       gg
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
        pg   = &p;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end
endmodule

module adder_32bits_cla #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned NCELL = WIDTH / 4;

    logic [NCELL:0]   c;
    logic [NCELL-1:0] pg;
    logic [NCELL-1:0] gg;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < NCELL; i++) begin : g_cell
            cla_4bit u_cell (
                .a   (a[4*i +: 4]),
                .b   (b[4*i +: 4]),
                .cin (c[i]),
                .sum (sum[4*i +: 4]),
                .pg  (pg[i]),
                .gg  (gg[i])
            );
            assign c[i+1] = gg[i] | (pg[i] & c[i]);
        end
    endgenerate

    assign cout = c[NCELL];
endmodule

// File: rtl/mult_unit.sv
// Multi-cycle shift-add multiplier for mult/multu writing HI/LO; one shared
// CLA adder serves both the accumulate loop and the final two's-complement fixup.
module mult_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CNT_W = $clog2(MUL_ITER);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITER - 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    mul_state_t       state, state_nx;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic             neg;
    logic             neg_c;

    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept;

    adder_32bits_cla #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Magnitudes of the most negative value stay as-is and read as unsigned.
    assign a_mag  = (is_signed && a[WIDTH-1]) ? (~a + ONE) : a;
    assign b_mag  = (is_signed && b[WIDTH-1]) ? (~b + ONE) : b;
    assign accept = start && (state == IDLE || state == DONE);

    assign busy = (state == CALC) || (state == NEG_LO) || (state == NEG_HI);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        case (state)
            IDLE: if (start) state_nx = CALC;
            CALC: begin
                add_a = hi;
                add_b = lo[0] ? mcand : '0;
                if (count == LAST_ITER) state_nx = neg ? NEG_LO : DONE;
            end
            NEG_LO: begin
                add_a    = ~lo;
                add_cin  = 1'b1;
                state_nx = NEG_HI;
            end
            NEG_HI: begin
                add_a    = ~hi;
                add_cin  = neg_c;
                state_nx = DONE;
            end
            DONE:    state_nx = start ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            count <= '0;
            neg   <= 1'b0;
            neg_c <= 1'b0;
        end else if (accept) begin
            mcand <= a_mag;
            lo    <= b_mag;
            hi    <= '0;
            count <= '0;
            neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else begin
            case (state)
                CALC: begin
                    {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
                    count    <= count + CNT_W'(1);
                end
                NEG_LO: begin
                    lo    <= add_sum;
                    neg_c <= add_cout;
                end
                NEG_HI:  hi <= add_sum;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_unit.sv
// Directed testbench for mult_unit: latency, products, handshake, reset.
module tb_mult_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int passed = 0;
    int total  = 0;

    mult_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Drive one start pulse; returns just after the accepting edge (E0).
    task automatic launch(input logic sgn, input logic [31:0] op_a, input logic [31:0] op_b);
        @(negedge clk);
        start = 1'b1; is_signed = sgn; a = op_a; b = op_b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; -1 when the bound expires.
    task automatic wait_done(input int already, output int lat);
        lat = already;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) return;
        end
        lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo got %h want 0", {hi, lo}); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_multu_small;
        int lat;
        launch(1'b0, 32'd7, 32'd6);
        total++; if (busy !== 1'b1) $display("FAIL small_busy_after_e0 got %b want 1", busy); else passed++;
        wait_done(0, lat);
        total++; if (lat !== 32) $display("FAIL small_latency got %0d want 32", lat); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL small_busy_at_done got %b want 0", busy); else passed++;
        total++; if (hi !== 32'h0) $display("FAIL small_hi got %h want 00000000", hi); else passed++;
        total++; if (lo !== 32'h2A) $display("FAIL small_lo got %h want 0000002a", lo); else passed++;
        @(posedge clk); #1;
        total++; if (done !== 1'b0) $display("FAIL small_done_pulse got %b want 0", done); else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({hi, lo} !== 64'h2A) $display("FAIL small_hold_idle got %h want 2a", {hi, lo}); else passed++;
    endtask

    task automatic test_mult_neg;
        int lat;
        launch(1'b1, 32'hFFFFFFFD, 32'd5);
        wait_done(0, lat);
        total++; if (lat !== 34) $display("FAIL neg_latency got %0d want 34", lat); else passed++;
        total++; if (hi !== 32'hFFFFFFFF) $display("FAIL neg_hi got %h want ffffffff", hi); else passed++;
        total++; if (lo !== 32'hFFFFFFF1) $display("FAIL neg_lo got %h want fffffff1", lo); else passed++;
    endtask

    task automatic test_all_ones;
        int lat;
        launch(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, lat);
        total++; if (lat !== 32) $display("FAIL ones_u_latency got %0d want 32", lat); else passed++;
        total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) $display("FAIL ones_u_product got %h want fffffffe00000001", {hi, lo}); else passed++;
        launch(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, lat);
        total++; if (lat !== 32) $display("FAIL ones_s_latency got %0d want 32", lat); else passed++;
        total++; if ({hi, lo} !== 64'h1) $display("FAIL ones_s_product got %h want 0000000000000001", {hi, lo}); else passed++;
    endtask

    task automatic test_min_int;
        int lat;
        launch(1'b1, 32'h80000000, 32'h80000000);
        wait_done(0, lat);
        total++; if (lat !== 32) $display("FAIL min_sq_latency got %0d want 32", lat); else passed++;
        total++; if ({hi, lo} !== 64'h40000000_00000000) $display("FAIL min_sq_product got %h want 4000000000000000", {hi, lo}); else passed++;
        launch(1'b1, 32'h80000000, 32'd1);
        wait_done(0, lat);
        total++; if (lat !== 34) $display("FAIL min_one_latency got %0d want 34", lat); else passed++;
        total++; if ({hi, lo} !== 64'hFFFFFFFF_80000000) $display("FAIL min_one_product got %h want ffffffff80000000", {hi, lo}); else passed++;
    endtask

    task automatic test_start_while_busy;
        int lat;
        launch(1'b1, 32'hFFFFFFFD, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd200;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(10, lat);
        total++; if (lat !== 34) $display("FAIL busy_start_latency got %0d want 34", lat); else passed++;
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) $display("FAIL busy_start_product got %h want fffffffffffffff1", {hi, lo}); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(1'b0, 32'd7, 32'd6);
        wait_done(0, lat);
        total++; if (lo !== 32'h2A) $display("FAIL b2b_first_lo got %h want 0000002a", lo); else passed++;
        start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL b2b_no_gap_busy got %b want 1", busy); else passed++;
        wait_done(0, lat);
        total++; if (lat !== 32) $display("FAIL b2b_second_latency got %0d want 32", lat); else passed++;
        total++; if ({hi, lo} !== 64'd12) $display("FAIL b2b_second_product got %h want 000000000000000c", {hi, lo}); else passed++;
    endtask

    task automatic test_reset_mid_op;
        int lat;
        launch(1'b1, 32'hFFFFFFFD, 32'd5);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else passed++;
        total++; if ({hi, lo} !== 64'h0) $display("FAIL midrst_hilo got %h want 0", {hi, lo}); else passed++;
        rst_n = 1'b1;
        launch(1'b0, 32'd3, 32'd4);
        wait_done(0, lat);
        total++; if (lat !== 32) $display("FAIL midrst_next_latency got %0d want 32", lat); else passed++;
        total++; if ({hi, lo} !== 64'd12) $display("FAIL midrst_next_product got %h want 000000000000000c", {hi, lo}); else passed++;
    endtask

    initial begin
        test_reset();
        test_multu_small();
        test_mult_neg();
        test_all_ones();
        test_min_int();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
